// File: rtl/axis_multichannel_frame_repeater.sv
// ---------------------------------------------------------------------------
// AxisMultichannelFrameRepeater
//
// Buffers one interleaved multichannel frame (one sample per channel, closed
// by tlast) and replays it `rate` times on the output stream, raising the
// frame rate by `rate`. A ping-pong pair of frame banks lets the next input
// frame be written while the current one is being replayed.
//
// Ports
//   aclk, aresetn    clock, synchronous active-low reset
//   rate             repetitions per input frame (0 behaves as 1), sampled
//                    when a new frame starts replaying
//   s_axis_*         input sample stream (tdata/tvalid/tlast/tready)
//   m_axis_tdata     replayed sample
//   m_axis_tvalid    output valid
//   m_axis_tlast     last sample of every repetition
//   m_axis_tuser     high on every beat of the first repetition of a frame
//   m_axis_tready    output ready
//
// Build option
//   AXIS_MULTICHANNEL_FRAME_REPEATER_ZERO_STUFF_EN: when defined, repetitions
//   2..rate carry zero data (zero-stuffing interpolation); otherwise every
//   repetition carries the stored samples (zero-order hold).
// ---------------------------------------------------------------------------
module axis_multichannel_frame_repeater #(
   parameter int DATA_WIDTH = 24,
   parameter int CHANNELS   = 1024,
   parameter int RATE_WIDTH = 8
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic [RATE_WIDTH-1:0] rate,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   input  logic                  s_axis_tlast,
   output logic                  s_axis_tready,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   output logic                  m_axis_tlast,
   output logic                  m_axis_tuser,
   input  logic                  m_axis_tready
);

   localparam int ADDR_WIDTH = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int LEN_WIDTH  = ADDR_WIDTH + 1;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(CHANNELS - 1);

   typedef enum logic {
      ST_IDLE,
      ST_PLAY
   } state_t;

   // Frame storage and per-bank bookkeeping
   logic [DATA_WIDTH-1:0] r_mem [2][CHANNELS];
   logic [LEN_WIDTH-1:0]  r_len [2];
   logic [1:0]            r_full;

   // Writer state
   logic                  r_inReset;
   logic                  r_wrSel;
   logic [ADDR_WIDTH-1:0] r_wrAddr;

   // Reader state
   state_t                r_state;
   logic                  r_rdSel;
   logic [ADDR_WIDTH-1:0] r_rdAddr;
   logic [RATE_WIDTH-1:0] r_repCnt;
   logic [RATE_WIDTH-1:0] r_repTarget;

   // Read pipeline stage (memory output register plus sideband)
   logic                  r_pipeValid;
   logic                  r_pipeLast;
   logic                  r_pipeUser;
   logic [DATA_WIDTH-1:0] r_rdData;
`ifdef AXIS_MULTICHANNEL_FRAME_REPEATER_ZERO_STUFF_EN
   logic                  r_pipeZero;
`endif

   // Two-entry output skid: r_out* drives the port, r_spare* holds overflow
   logic                  r_outValid;
   logic [DATA_WIDTH-1:0] r_outData;
   logic                  r_outLast;
   logic                  r_outUser;
   logic                  r_spareValid;
   logic [DATA_WIDTH-1:0] r_spareData;
   logic                  r_spareLast;
   logic                  r_spareUser;

   logic                  w_wrFire;
   logic                  w_wrEnd;
   logic                  w_otherSel;
   logic [LEN_WIDTH-1:0]  w_lenM1;
   logic                  w_atEnd;
   logic                  w_lastRep;
   logic [RATE_WIDTH-1:0] w_rateEff;
   logic                  w_pop;
   logic [1:0]            w_occ;
   logic                  w_credit;
   logic                  w_issue;
   logic                  w_clrFull;
   logic [DATA_WIDTH-1:0] w_pipeData;

   // Writer-side handshake and frame-closing condition. A frame closes on
   // tlast or when the bank is full; surplus samples start the next frame.
   assign s_axis_tready = !r_full[r_wrSel] && !r_inReset;
   assign w_wrFire      = s_axis_tvalid && s_axis_tready;
   assign w_wrEnd       = s_axis_tlast || (r_wrAddr == LAST_ADDR);

   // Reader-side decode of the current position within the replay
   assign w_otherSel = ~r_rdSel;
   assign w_lenM1    = r_len[r_rdSel] - LEN_WIDTH'(1);
   assign w_atEnd    = ({1'b0, r_rdAddr} == w_lenM1);
   assign w_lastRep  = (r_repCnt == (r_repTarget - RATE_WIDTH'(1)));
   assign w_rateEff  = (rate == '0) ? RATE_WIDTH'(1) : rate;

   // A read is only issued if the skid can take it a cycle later: the
   // entries already held plus the one in flight, minus the beat leaving
   // this cycle, must leave room.
   assign w_pop    = r_outValid && m_axis_tready;
   assign w_occ    = {1'b0, r_outValid} + {1'b0, r_spareValid} + {1'b0, r_pipeValid};
   assign w_credit = ((w_occ - {1'b0, w_pop}) < 2'd2);
   assign w_issue  = (r_state == ST_PLAY) && w_credit;

   // The bank is released when the very last read of its last repetition
   // is issued, so the writer can refill it while the tail drains.
   assign w_clrFull = w_issue && w_atEnd && w_lastRep;

`ifdef AXIS_MULTICHANNEL_FRAME_REPEATER_ZERO_STUFF_EN
   assign w_pipeData = r_pipeZero ? '0 : r_rdData;
`else
   assign w_pipeData = r_rdData;
`endif

   // Frame memory: write port from the input stream, registered read port
   // feeding the output pipeline. Contents need no reset because the full
   // flags and lengths gate every read.
   always_ff @(posedge aclk) begin
      if (w_wrFire) begin
         r_mem[r_wrSel][r_wrAddr] <= s_axis_tdata;
      end
      if (w_issue) begin
         r_rdData <= r_mem[r_rdSel][r_rdAddr];
      end
   end

   // Writer: fills the selected bank, records its length when the frame
   // closes and hands the bank over to the reader.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_inReset <= 1'b1;
         r_wrSel   <= 1'b0;
         r_wrAddr  <= '0;
         r_len[0]  <= '0;
         r_len[1]  <= '0;
      end else begin
         r_inReset <= 1'b0;
         if (w_wrFire) begin
            if (w_wrEnd) begin
               r_len[r_wrSel] <= {1'b0, r_wrAddr} + LEN_WIDTH'(1);
               r_wrSel        <= ~r_wrSel;
               r_wrAddr       <= '0;
            end else begin
               r_wrAddr <= r_wrAddr + ADDR_WIDTH'(1);
            end
         end
      end
   end

   // Bank ownership flags. The writer sets the flag of r_wrSel and the
   // reader clears the flag of r_rdSel; when both act in one cycle they
   // touch different banks, so both updates land.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_full <= 2'b00;
      end else begin
         if (w_wrFire && w_wrEnd) begin
            r_full[r_wrSel] <= 1'b1;
         end
         if (w_clrFull) begin
            r_full[r_rdSel] <= 1'b0;
         end
      end
   end

   // Reader FSM: waits for a full bank, latches the repetition count, then
   // walks the stored frame once per repetition. When the other bank is
   // already waiting it chains straight into it with no idle cycle.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_state     <= ST_IDLE;
         r_rdSel     <= 1'b0;
         r_rdAddr    <= '0;
         r_repCnt    <= '0;
         r_repTarget <= RATE_WIDTH'(1);
         r_pipeValid <= 1'b0;
         r_pipeLast  <= 1'b0;
         r_pipeUser  <= 1'b0;
`ifdef AXIS_MULTICHANNEL_FRAME_REPEATER_ZERO_STUFF_EN
         r_pipeZero  <= 1'b0;
`endif
      end else begin
         r_pipeValid <= w_issue;
         if (w_issue) begin
            r_pipeLast <= w_atEnd;
            r_pipeUser <= (r_repCnt == '0);
`ifdef AXIS_MULTICHANNEL_FRAME_REPEATER_ZERO_STUFF_EN
            r_pipeZero <= (r_repCnt != '0);
`endif
         end
         case (r_state)
            ST_IDLE: begin
               if (r_full[r_rdSel]) begin
                  r_repTarget <= w_rateEff;
                  r_repCnt    <= '0;
                  r_rdAddr    <= '0;
                  r_state     <= ST_PLAY;
               end
            end
            ST_PLAY: begin
               if (w_issue) begin
                  if (w_atEnd) begin
                     r_rdAddr <= '0;
                     if (w_lastRep) begin
                        r_rdSel  <= w_otherSel;
                        r_repCnt <= '0;
                        if (r_full[w_otherSel]) begin
                           r_repTarget <= w_rateEff;
                        end else begin
                           r_state <= ST_IDLE;
                        end
                     end else begin
                        r_repCnt <= r_repCnt + RATE_WIDTH'(1);
                     end
                  end else begin
                     r_rdAddr <= r_rdAddr + ADDR_WIDTH'(1);
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Output skid: keeps the port fully registered and absorbs the one beat
   // that is already in flight when the consumer stalls.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_outValid   <= 1'b0;
         r_outData    <= '0;
         r_outLast    <= 1'b0;
         r_outUser    <= 1'b0;
         r_spareValid <= 1'b0;
         r_spareData  <= '0;
         r_spareLast  <= 1'b0;
         r_spareUser  <= 1'b0;
      end else begin
         case ({r_pipeValid, w_pop})
            2'b01: begin
               if (r_spareValid) begin
                  r_outData    <= r_spareData;
                  r_outLast    <= r_spareLast;
                  r_outUser    <= r_spareUser;
                  r_spareValid <= 1'b0;
               end else begin
                  r_outValid <= 1'b0;
               end
            end
            2'b10: begin
               if (!r_outValid) begin
                  r_outValid <= 1'b1;
                  r_outData  <= w_pipeData;
                  r_outLast  <= r_pipeLast;
                  r_outUser  <= r_pipeUser;
               end else begin
                  r_spareValid <= 1'b1;
                  r_spareData  <= w_pipeData;
                  r_spareLast  <= r_pipeLast;
                  r_spareUser  <= r_pipeUser;
               end
            end
            2'b11: begin
               if (r_spareValid) begin
                  r_outData   <= r_spareData;
                  r_outLast   <= r_spareLast;
                  r_outUser   <= r_spareUser;
                  r_spareData <= w_pipeData;
                  r_spareLast <= r_pipeLast;
                  r_spareUser <= r_pipeUser;
               end else begin
                  r_outData <= w_pipeData;
                  r_outLast <= r_pipeLast;
                  r_outUser <= r_pipeUser;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign m_axis_tvalid = r_outValid;
   assign m_axis_tdata  = r_outData;
   assign m_axis_tlast  = r_outLast;
   assign m_axis_tuser  = r_outUser;

endmodule

// File: tb/tb_axis_multichannel_frame_repeater.sv
// ---------------------------------------------------------------------------
// Bench for axis_multichannel_frame_repeater with CHANNELS = 8.
// The reference model turns every accepted input frame into its expected
// output beats (frame split at tlast or at CHANNELS samples, repeated the
// number of times the stimulus declares) and a monitor compares every
// output handshake against that queue, plus stall stability each cycle.
// ---------------------------------------------------------------------------
module tb_axis_multichannel_frame_repeater;

   localparam int DW = 24;
   localparam int CH = 8;
   localparam int RW = 8;

   typedef struct {
      logic [DW-1:0] data;
      logic          last;
      logic          user;
   } beat_t;

   logic          aclk = 1'b0;
   logic          aresetn = 1'b0;
   logic [RW-1:0] rate = 8'd1;
   logic [DW-1:0] s_axis_tdata = '0;
   logic          s_axis_tvalid = 1'b0;
   logic          s_axis_tlast = 1'b0;
   logic          s_axis_tready;
   logic [DW-1:0] m_axis_tdata;
   logic          m_axis_tvalid;
   logic          m_axis_tlast;
   logic          m_axis_tuser;
   logic          m_axis_tready = 1'b1;

   int testsRun = 0;
   int testsFailed = 0;

   beat_t         expQ[$];
   logic [DW-1:0] curFrame[$];
   int            repsQ[$];

   bit            randReady = 1'b0;
   int            cycle = 0;
   int            beatCount = 0;
   int            lastCount = 0;
   int            userCount = 0;
   int            firstCyc = -1;
   int            lastCyc = -1;
   logic [DW-1:0] firstData = '0;

   bit            prevStall = 1'b0;
   logic [DW-1:0] stallData;
   logic          stallLast;
   logic          stallUser;

   axis_multichannel_frame_repeater #(
      .DATA_WIDTH(DW),
      .CHANNELS  (CH),
      .RATE_WIDTH(RW)
   ) dut (
      .aclk         (aclk),
      .aresetn      (aresetn),
      .rate         (rate),
      .s_axis_tdata (s_axis_tdata),
      .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tlast (s_axis_tlast),
      .s_axis_tready(s_axis_tready),
      .m_axis_tdata (m_axis_tdata),
      .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tlast (m_axis_tlast),
      .m_axis_tuser (m_axis_tuser),
      .m_axis_tready(m_axis_tready)
   );

   always #5 aclk = ~aclk;

   // Literal comparison helper
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Declares how many times the next closed input frame must be replayed
   task automatic expectFrame(input int reps);
      repsQ.push_back(reps);
   endtask

   // Reference model: an accepted sample extends the open frame; a frame
   // closes on tlast or after CH samples and expands into reps copies.
   task automatic modelAccept(input logic [DW-1:0] d, input logic l);
      int    reps;
      int    n;
      beat_t b;
      curFrame.push_back(d);
      if (l || curFrame.size() == CH) begin
         if (repsQ.size() == 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL model_reps: got no declared repetition count, expected one");
            reps = 1;
         end else begin
            reps = repsQ.pop_front();
         end
         n = curFrame.size();
         for (int r = 0; r < reps; r++) begin
            for (int i = 0; i < n; i++) begin
               b.data = curFrame[i];
`ifdef AXIS_MULTICHANNEL_FRAME_REPEATER_ZERO_STUFF_EN
               if (r > 0) b.data = '0;
`endif
               b.last = (i == n - 1);
               b.user = (r == 0);
               expQ.push_back(b);
            end
         end
         curFrame.delete();
      end
   endtask

   // Drives one input beat from a negedge and holds it until accepted
   task automatic sendBeat(input logic [DW-1:0] d, input logic l);
      logic acc;
      int   waitCnt;
      acc = 1'b0;
      waitCnt = 0;
      s_axis_tdata  = d;
      s_axis_tlast  = l;
      s_axis_tvalid = 1'b1;
      while (!acc) begin
         acc = s_axis_tready;
         @(posedge aclk);
         @(negedge aclk);
         if (!acc) begin
            waitCnt++;
            if (waitCnt > 2000) begin
               testsRun++;
               testsFailed++;
               $display("[TB] FAIL input_timeout: got no s_axis_tready in 2000 cycles, expected acceptance");
               break;
            end
         end
      end
      if (acc) modelAccept(d, l);
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
   endtask

   // Sends n samples base..base+n-1, tlast on the final one when withLast
   task automatic applyStimulus(input int base, input int n, input bit withLast);
      for (int i = 0; i < n; i++) begin
         sendBeat(DW'(base + i), withLast && (i == n - 1));
      end
   endtask

   // Waits until every expected beat has left the DUT
   task automatic waitDrain();
      int n;
      n = 0;
      while ((expQ.size() != 0 || m_axis_tvalid) && n < 3000) begin
         @(negedge aclk);
         n++;
      end
      if (n >= 3000) begin
         testsRun++;
         testsFailed++;
         $display("[TB] FAIL drain_timeout: got %0d beats outstanding, expected 0", expQ.size());
      end
      repeat (4) @(negedge aclk);
   endtask

   task automatic resetCounters();
      beatCount = 0;
      lastCount = 0;
      userCount = 0;
      firstCyc  = -1;
      lastCyc   = -1;
   endtask

   // Asserts reset for several cycles, checks the output is dropped at once
   // and reset values are held, then checks s_axis_tready rises one cycle
   // after reset is released.
   task automatic doReset(input int cycles);
      aresetn = 1'b0;
      expQ.delete();
      curFrame.delete();
      repsQ.delete();
      @(negedge aclk);
      checkOutput("reset_valid_drop", 32'(m_axis_tvalid), 32'd0);
      repeat (cycles) @(negedge aclk);
      checkOutput("reset_s_tready", 32'(s_axis_tready), 32'd0);
      checkOutput("reset_m_tvalid", 32'(m_axis_tvalid), 32'd0);
      checkOutput("reset_m_tlast", 32'(m_axis_tlast), 32'd0);
      checkOutput("reset_m_tuser", 32'(m_axis_tuser), 32'd0);
      checkOutput("reset_m_tdata", 32'(m_axis_tdata), 32'd0);
      aresetn = 1'b1;
      checkOutput("tready_before_release_edge", 32'(s_axis_tready), 32'd0);
      @(negedge aclk);
      checkOutput("tready_after_release_edge", 32'(s_axis_tready), 32'd1);
   endtask

   // Monitor: runs just after each negedge, once the stimulus for the
   // coming edge is in place. It checks that a stalled beat is held, picks
   // m_axis_tready for the next edge and scores any beat that will transfer.
   always @(negedge aclk) begin
      #1;
      cycle++;
      if (!aresetn) begin
         prevStall = 1'b0;
      end else begin
         if (prevStall) begin
            testsRun++;
            if (!m_axis_tvalid || m_axis_tdata !== stallData ||
                m_axis_tlast !== stallLast || m_axis_tuser !== stallUser) begin
               testsFailed++;
               $display("[TB] FAIL stall_hold: got valid=%0b data=%0d last=%0b user=%0b, expected valid=1 data=%0d last=%0b user=%0b",
                        m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser, stallData, stallLast, stallUser);
            end
         end
         m_axis_tready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
         if (m_axis_tvalid && m_axis_tready) begin
            testsRun++;
            if (expQ.size() == 0) begin
               testsFailed++;
               $display("[TB] FAIL unexpected_beat: got data=%0d, expected no beat", m_axis_tdata);
            end else begin
               beat_t e;
               e = expQ.pop_front();
               if (m_axis_tdata !== e.data || m_axis_tlast !== e.last || m_axis_tuser !== e.user) begin
                  testsFailed++;
                  $display("[TB] FAIL beat: got data=%0d last=%0b user=%0b, expected data=%0d last=%0b user=%0b",
                           m_axis_tdata, m_axis_tlast, m_axis_tuser, e.data, e.last, e.user);
               end
            end
            if (firstCyc < 0) begin
               firstCyc  = cycle;
               firstData = m_axis_tdata;
            end
            lastCyc = cycle;
            beatCount++;
            if (m_axis_tlast) lastCount++;
            if (m_axis_tuser) userCount++;
         end
         prevStall = m_axis_tvalid && !m_axis_tready;
         stallData = m_axis_tdata;
         stallLast = m_axis_tlast;
         stallUser = m_axis_tuser;
      end
   end

   initial begin
      @(negedge aclk);
      doReset(4);

      // Single frame, rate 3, full-speed consumer; latency from tlast edge
      resetCounters();
      rate = 8'd3;
      expectFrame(3);
      applyStimulus(1, 8, 1'b1);
      @(negedge aclk);
      @(negedge aclk);
      checkOutput("latency_not_yet_valid", 32'(m_axis_tvalid), 32'd0);
      @(negedge aclk);
      checkOutput("latency_first_valid", 32'(m_axis_tvalid), 32'd1);
      waitDrain();
      checkOutput("t1_first_data", 32'(firstData), 32'd1);
      checkOutput("t1_beats", 32'(beatCount), 32'd24);
      checkOutput("t1_tlast_count", 32'(lastCount), 32'd3);
      checkOutput("t1_tuser_count", 32'(userCount), 32'd8);

      // Back-to-back frames A and B at rate 2: no output gap, input blocked
      resetCounters();
      rate = 8'd2;
      expectFrame(2);
      expectFrame(2);
      applyStimulus(1, 8, 1'b1);
      applyStimulus(9, 8, 1'b1);
      checkOutput("t2_tready_low_both_full", 32'(s_axis_tready), 32'd0);
      waitDrain();
      checkOutput("t2_beats", 32'(beatCount), 32'd32);
      checkOutput("t2_span_no_gap", 32'(lastCyc - firstCyc), 32'd31);

      // rate 0 and rate 1 both give a single pass
      resetCounters();
      rate = 8'd0;
      expectFrame(1);
      applyStimulus(40, 8, 1'b1);
      waitDrain();
      rate = 8'd1;
      expectFrame(1);
      applyStimulus(60, 8, 1'b1);
      waitDrain();
      checkOutput("t3_single_pass_beats", 32'(beatCount), 32'd16);
      checkOutput("t3_single_pass_users", 32'(userCount), 32'd16);

      // rate changed to 4 after frame C started: C keeps 2, D gets 4
      resetCounters();
      rate = 8'd2;
      expectFrame(2);
      expectFrame(4);
      applyStimulus(100, 4, 1'b1);
      sendBeat(DW'(200), 1'b0);
      rate = 8'd4;
      applyStimulus(201, 3, 1'b1);
      waitDrain();
      checkOutput("t3_rate_change_beats", 32'(beatCount), 32'd24);
      checkOutput("t3_rate_change_lasts", 32'(lastCount), 32'd6);

      // Short frame of 5, then a 10-sample burst split at CH
      resetCounters();
      rate = 8'd1;
      expectFrame(1);
      expectFrame(1);
      expectFrame(1);
      applyStimulus(300, 5, 1'b1);
      applyStimulus(400, 10, 1'b1);
      waitDrain();
      checkOutput("t4_beats", 32'(beatCount), 32'd15);
      checkOutput("t4_lasts", 32'(lastCount), 32'd3);

      // Random consumer backpressure at rate 2
      resetCounters();
      randReady = 1'b1;
      rate = 8'd2;
      for (int f = 0; f < 3; f++) begin
         expectFrame(2);
         applyStimulus(1000 + 16 * f + int'($urandom_range(0, 7)), 8, 1'b1);
      end
      waitDrain();
      randReady = 1'b0;
      checkOutput("t5_beats", 32'(beatCount), 32'd48);

      // Reset in the middle of a replay, then a clean frame afterwards
      rate = 8'd3;
      expectFrame(3);
      applyStimulus(500, 8, 1'b1);
      repeat (6) @(negedge aclk);
      doReset(3);
      resetCounters();
      rate = 8'd3;
      expectFrame(3);
      applyStimulus(1, 8, 1'b1);
      waitDrain();
      checkOutput("t6_beats_after_reset", 32'(beatCount), 32'd24);
      checkOutput("t6_first_data", 32'(firstData), 32'd1);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
